mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer that shares one unified memory port between the instruction-fetch stage and the memory stage of the in-order single-issue pipeline. It allows one outstanding transaction at a time and routes each response back to its owner. It also drives per-requester stall outputs consumed by dependency_ctrl and honours branch-redirect flushes. It sits between if_stage/mem_stage and the external memory model.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables are DATA_W/8)
- STARVE_LIMIT, 4, consecutive fetch losses before fetch is forced to win (range 1..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  branch redirect; kills the in-flight or pending fetch
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse when the fetch is latched
- if_rvalid  out  1  fetch response valid, one cycle
- if_rdata  out  DATA_W  fetch data
- dm_req  in  1  load/store request, held until dm_gnt
- dm_we  in  1  1 = store
- dm_be  in  DATA_W/8  byte enables
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  one-cycle pulse when the data request is latched
- dm_rvalid  out  1  data response (load data or store ack), one cycle
- dm_rdata  out  DATA_W  load data
- mem_req, mem_we, mem_be, mem_addr, mem_wdata  out  1/1/DATA_W/8/ADDR_W/DATA_W  registered downstream request
- mem_ready  in  1  downstream accepts the request while mem_req=1
- mem_rvalid  in  1  downstream response; also returned for stores
- mem_rdata  in  DATA_W  downstream read data
- stall_if_arb  out  1  if_req & ~if_rvalid
- stall_mem_arb  out  1  dm_req & ~dm_rvalid

## Operation
- FSM states: IDLE, ISSUE, WAIT. The owner register is IF or DM.
- IDLE: if any eligible request exists, pick a winner, latch its address, data and controls into the mem_* registers, pulse its gnt, and go to ISSUE.
- Default priority: DM wins over IF, because the older instruction goes first.
- Eligibility:
  - A request is ineligible in the cycle its own rvalid is asserted, since the requester may still be holding the old request.
  - if_req is ineligible in any cycle where flush=1.
- ISSUE: mem_req=1, with all mem_* signals held stable until mem_ready, then go to WAIT. mem_req never drops without mem_ready.
- WAIT: on mem_rvalid, register mem_rdata into the owner's rdata, pulse the owner's rvalid in the next cycle, and return to IDLE in that same next cycle.
- Flush:
  - Flush while the owner is IF in ISSUE or WAIT sets a kill flag. The transaction still completes downstream, but if_rvalid is suppressed and the kill flag is cleared on return to IDLE.
  - Flush has no effect on a DM-owned transaction.
- mem_rvalid is ignored in IDLE and ISSUE. The memory model must not produce it there; the bench flags it as an error.
- rdata outputs hold their last value between responses.
- Reset: state IDLE, owner IF, kill 0, starvation counter 0, all outputs 0.

## Timing
- Cycle 0: request is latched in IDLE and gnt is pulsed.
- Cycle 1: mem_req rises.
- With mem_ready in cycle 1 and mem_rvalid in cycle 2, rvalid appears in cycle 3.
- Minimum request-to-response latency is 3 cycles; back-to-back grant spacing is 3 cycles.
- The next arbitration happens in the rvalid cycle, and in that cycle the just-completed requester is excluded.
- Simultaneous flush and if_gnt cannot occur, because if_req is ineligible under flush.
- Simultaneous flush and mem_rvalid on an IF transaction: the response is dropped.
- Reset asserted mid-transaction aborts it immediately. The downstream model must be reset together with the arbiter.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A 4-bit counter increments on each IDLE arbitration in which IF is eligible and loses to DM.
  - When the counter equals STARVE_LIMIT, IF wins the next contested arbitration.
  - The counter clears when IF is granted or when if_req=0.
  - The counter saturates at STARVE_LIMIT.
- ARB_STARVE_GUARD_EN undefined: strict DM priority; no counter logic.

## Test plan
- Single fetch: if_req, addr 0x100; mem_ready immediately; mem_rvalid 1 cycle later with 0xDEADBEEF -> if_gnt at cycle 0, mem_req cycles 1 only, if_rvalid with if_rdata 0xDEADBEEF at cycle 3.
- Contention: if_req and dm_req (store, be 0xF, addr 0x200) asserted together -> dm_gnt first with mem_we=1; the fetch is granted in the cycle dm_rvalid pulses; stall_if_arb stays high throughout.
- Backpressure: mem_ready low for 5 cycles -> mem_req and mem_addr stable for 6 cycles, no second gnt, then normal completion.
- Flush in WAIT: fetch 0x104 in flight, flush pulsed, then mem_rvalid -> no if_rvalid pulse; a new fetch to 0x300 is granted the following IDLE cycle.
- Starvation (macro on, STARVE_LIMIT=2): continuous dm_req and if_req -> IF wins after exactly 2 DM grants. With the macro off, IF is never granted while dm_req is held.
- Reset mid-WAIT -> next cycle all outputs 0, state IDLE, late mem_rvalid produces no rvalid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares a single unified memory port between instruction fetch (IF) and the
// memory stage (DM). Only one transaction is outstanding at a time, and each
// response is routed back to the requester that owns it. The block also drives
// per-requester stall outputs and drops fetch responses killed by a branch
// redirect (flush).
//
// Optional feature: define ARB_STARVE_GUARD_EN to add a fetch starvation guard.
// With the guard, fetch wins a contested arbitration after it has lost
// STARVE_LIMIT contested arbitrations in a row. Without it, the data port
// always wins a contested arbitration.

module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [DATA_W/8-1:0] dm_be,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   output logic                dm_gnt,
   output logic                dm_rvalid,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_ready,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                stall_if_arb,
   output logic                stall_mem_arb
);

   // The starvation counter is 4 bits wide, so the limit must fit in 1..15.
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_badStarveLimit
      $error("mem_port_arbiter: STARVE_LIMIT must be in the range 1..15");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arbState_t;

   typedef enum logic {
      OWNER_IF = 1'b0,
      OWNER_DM = 1'b1
   } owner_t;

   arbState_t state_q, state_d;
   owner_t    owner_q, owner_d;
   logic      kill_q, kill_d;

   logic                memReq_q, memReq_d;
   logic                memWe_q, memWe_d;
   logic [DATA_W/8-1:0] memBe_q, memBe_d;
   logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
   logic [DATA_W-1:0]   memWdata_q, memWdata_d;

   logic                ifRvalid_q, ifRvalid_d;
   logic                dmRvalid_q, dmRvalid_d;
   logic [DATA_W-1:0]   ifRdata_q, ifRdata_d;
   logic [DATA_W-1:0]   dmRdata_q, dmRdata_d;

   logic ifEligible;
   logic dmEligible;
   logic contested;
   logic starveWinIf;
   logic pickIf;
   logic pickDm;
   logic grantIf;
   logic grantDm;
   logic respond;

   // Eligibility and winner selection. A requester whose response is being
   // returned this cycle may still be presenting the old request, so it sits
   // this round out. A fetch under flush is about to be redirected, so it is
   // never picked. The data port wins ties unless the starvation guard fires.
   always_comb begin
      ifEligible = if_req & ~ifRvalid_q & ~flush;
      dmEligible = dm_req & ~dmRvalid_q;
      contested  = ifEligible & dmEligible;
      pickIf     = 1'b0;
      pickDm     = 1'b0;
      if (contested) begin
         if (starveWinIf) begin
            pickIf = 1'b1;
         end else begin
            pickDm = 1'b1;
         end
      end else if (ifEligible) begin
         pickIf = 1'b1;
      end else if (dmEligible) begin
         pickDm = 1'b1;
      end
   end

`ifdef ARB_STARVE_GUARD_EN
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   logic [3:0] starveCnt_q, starveCnt_d;

   // Count consecutive contested arbitrations that fetch loses; saturate at the
   // limit and forget the history once fetch is served or stops asking.
   always_comb begin
      starveCnt_d = starveCnt_q;
      if (grantIf | ~if_req) begin
         starveCnt_d = 4'd0;
      end else if (grantDm & contested & (starveCnt_q != STARVE_MAX)) begin
         starveCnt_d = starveCnt_q + 4'd1;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         starveCnt_q <= 4'd0;
      end else begin
         starveCnt_q <= starveCnt_d;
      end
   end

   assign starveWinIf = (starveCnt_q == STARVE_MAX);
`else
   assign starveWinIf = 1'b0;
`endif

   // FSM state register, including the owner of the transaction and the kill flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= OWNER_IF;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         kill_q  <= kill_d;
      end
   end

   // FSM next state: grant in IDLE, hold the request in ISSUE until it is
   // accepted, then wait for the single response before going back to IDLE.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      kill_d  = kill_q;
      unique case (state_q)
         IDLE: begin
            kill_d = 1'b0;
            if (pickIf | pickDm) begin
               state_d = ISSUE;
               owner_d = pickDm ? OWNER_DM : OWNER_IF;
            end
         end
         ISSUE: begin
            if (flush & (owner_q == OWNER_IF)) begin
               kill_d = 1'b1;
            end
            if (mem_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (flush & (owner_q == OWNER_IF)) begin
               kill_d = 1'b1;
            end
            if (mem_rvalid) begin
               state_d = IDLE;
               kill_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            kill_d  = 1'b0;
         end
      endcase
   end

   // FSM outputs: grant pulses in IDLE, and the response strobe in WAIT. A
   // response arriving in IDLE or ISSUE is not ours and is ignored.
   always_comb begin
      grantIf = (state_q == IDLE) & pickIf & ~reset;
      grantDm = (state_q == IDLE) & pickDm & ~reset;
      respond = (state_q == WAIT) & mem_rvalid;
   end

   // Downstream request next state: load the winner's request on a grant, and
   // drop mem_req only once the memory has accepted it. Fetches always read a
   // full word.
   always_comb begin
      memReq_d   = memReq_q;
      memWe_d    = memWe_q;
      memBe_d    = memBe_q;
      memAddr_d  = memAddr_q;
      memWdata_d = memWdata_q;
      if (grantDm) begin
         memReq_d   = 1'b1;
         memWe_d    = dm_we;
         memBe_d    = dm_be;
         memAddr_d  = dm_addr;
         memWdata_d = dm_wdata;
      end else if (grantIf) begin
         memReq_d   = 1'b1;
         memWe_d    = 1'b0;
         memBe_d    = '1;
         memAddr_d  = if_addr;
         memWdata_d = '0;
      end else if (memReq_q & mem_ready) begin
         memReq_d = 1'b0;
      end
   end

   // Response routing: pulse the owner's rvalid one cycle after mem_rvalid. A
   // fetch killed by a flush, now or earlier in the transaction, gets no pulse.
   // Read data holds its last value between responses.
   always_comb begin
      ifRvalid_d = respond & (owner_q == OWNER_IF) & ~kill_q & ~flush;
      dmRvalid_d = respond & (owner_q == OWNER_DM);
      ifRdata_d  = ifRvalid_d ? mem_rdata : ifRdata_q;
      dmRdata_d  = dmRvalid_d ? mem_rdata : dmRdata_q;
   end

   // Datapath registers for the downstream request and both response channels.
   always_ff @(posedge clk) begin
      if (reset) begin
         memReq_q   <= 1'b0;
         memWe_q    <= 1'b0;
         memBe_q    <= '0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
         ifRvalid_q <= 1'b0;
         dmRvalid_q <= 1'b0;
         ifRdata_q  <= '0;
         dmRdata_q  <= '0;
      end else begin
         memReq_q   <= memReq_d;
         memWe_q    <= memWe_d;
         memBe_q    <= memBe_d;
         memAddr_q  <= memAddr_d;
         memWdata_q <= memWdata_d;
         ifRvalid_q <= ifRvalid_d;
         dmRvalid_q <= dmRvalid_d;
         ifRdata_q  <= ifRdata_d;
         dmRdata_q  <= dmRdata_d;
      end
   end

   assign if_gnt        = grantIf;
   assign dm_gnt        = grantDm;
   assign if_rvalid     = ifRvalid_q;
   assign dm_rvalid     = dmRvalid_q;
   assign if_rdata      = ifRdata_q;
   assign dm_rdata      = dmRdata_q;
   assign mem_req       = memReq_q;
   assign mem_we        = memWe_q;
   assign mem_be        = memBe_q;
   assign mem_addr      = memAddr_q;
   assign mem_wdata     = memWdata_q;
   assign stall_if_arb  = if_req & ~ifRvalid_q;
   assign stall_mem_arb = dm_req & ~dmRvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed scenarios followed by randomized traffic. The reference model tracks
// the single outstanding transaction as a record (owner, request fields,
// accepted, killed) plus the response to deliver next cycle, and predicts
// every DUT output each cycle. Follows ARB_STARVE_GUARD_EN when it is defined.

module tb_mem_port_arbiter;

   localparam int ADDR_W       = 32;
   localparam int DATA_W       = 32;
   localparam int BE_W         = DATA_W / 8;
   localparam int STARVE_LIMIT = 2;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD_ON = 1'b1;
`else
   localparam bit GUARD_ON = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset = 1'b1, flush = 1'b0;
   logic              if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0, dm_addr = '0;
   logic [BE_W-1:0]   dm_be = '0;
   logic [DATA_W-1:0] dm_wdata = '0, mem_rdata = '0;
   logic              mem_ready = 1'b0, mem_rvalid = 1'b0;
   logic              if_gnt, if_rvalid, dm_gnt, dm_rvalid;
   logic [DATA_W-1:0] if_rdata, dm_rdata, mem_wdata;
   logic              mem_req, mem_we, stall_if_arb, stall_mem_arb;
   logic [BE_W-1:0]   mem_be;
   logic [ADDR_W-1:0] mem_addr;

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
      .dm_rdata(dm_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .stall_if_arb(stall_if_arb), .stall_mem_arb(stall_mem_arb)
   );

   int checksTotal  = 0;
   int checksPassed = 0;

   // Stimulus for the next cycle; copied onto the DUT pins at the falling edge.
   logic              bReset, bFlush, bIfReq, bDmReq, bDmWe, bMemReady, bMemRvalid;
   logic [ADDR_W-1:0] bIfAddr, bDmAddr;
   logic [BE_W-1:0]   bDmBe;
   logic [DATA_W-1:0] bDmWdata, bMemRdata;

   // Reference model: the one outstanding transaction and the pending response.
   logic              mTxnValid, mTxnOwnerDm, mTxnAccepted, mTxnKilled, mTxnWe;
   logic [ADDR_W-1:0] mTxnAddr;
   logic [BE_W-1:0]   mTxnBe;
   logic [DATA_W-1:0] mTxnWdata;
   logic              mRespIf, mRespDm;
   logic [DATA_W-1:0] mIfData, mDmData;
   int                mStarve;

   // Random-traffic agents (requesters and memory).
   logic lastIfGnt, lastDmGnt, lastAccepted, lastMemRvalid;
   logic ifPending, dmPending, memBusy;
   int   memDelay;

   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checksTotal++;
      if (actual === expected) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic resetModel();
      mTxnValid = 1'b0; mTxnOwnerDm = 1'b0; mTxnAccepted = 1'b0; mTxnKilled = 1'b0;
      mTxnWe = 1'b0; mTxnAddr = '0; mTxnBe = '0; mTxnWdata = '0;
      mRespIf = 1'b0; mRespDm = 1'b0; mIfData = '0; mDmData = '0; mStarve = 0;
   endtask

   task automatic clearInputs();
      bReset = 1'b0; bFlush = 1'b0; bIfReq = 1'b0; bDmReq = 1'b0; bDmWe = 1'b0;
      bMemReady = 1'b0; bMemRvalid = 1'b0; bIfAddr = '0; bDmAddr = '0;
      bDmBe = '0; bDmWdata = '0; bMemRdata = '0;
   endtask

   // One clock cycle: drive inputs, predict and compare all outputs, then
   // advance the reference model across the coming rising edge.
   task automatic applyStimulus();
      logic eIfRvalid, eDmRvalid, ifElig, dmElig, eIfGnt, eDmGnt, eMemReq;
      logic nIf, nDm;
      @(negedge clk);
      reset = bReset; flush = bFlush;
      if_req = bIfReq; if_addr = bIfAddr;
      dm_req = bDmReq; dm_we = bDmWe; dm_be = bDmBe; dm_addr = bDmAddr; dm_wdata = bDmWdata;
      mem_ready = bMemReady; mem_rvalid = bMemRvalid; mem_rdata = bMemRdata;
      #1;
      eIfRvalid = mRespIf;
      eDmRvalid = mRespDm;
      ifElig = bIfReq && !eIfRvalid && !bFlush;
      dmElig = bDmReq && !eDmRvalid;
      eIfGnt = 1'b0;
      eDmGnt = 1'b0;
      if (!bReset && !mTxnValid) begin
         if (ifElig && dmElig) begin
            if (GUARD_ON && mStarve == STARVE_LIMIT) eIfGnt = 1'b1;
            else eDmGnt = 1'b1;
         end else if (ifElig) begin
            eIfGnt = 1'b1;
         end else if (dmElig) begin
            eDmGnt = 1'b1;
         end
      end
      eMemReq = mTxnValid && !mTxnAccepted;
      checkOutput("if_gnt", 64'(if_gnt), 64'(eIfGnt));
      checkOutput("dm_gnt", 64'(dm_gnt), 64'(eDmGnt));
      checkOutput("if_rvalid", 64'(if_rvalid), 64'(eIfRvalid));
      checkOutput("dm_rvalid", 64'(dm_rvalid), 64'(eDmRvalid));
      checkOutput("if_rdata", 64'(if_rdata), 64'(mIfData));
      checkOutput("dm_rdata", 64'(dm_rdata), 64'(mDmData));
      checkOutput("mem_req", 64'(mem_req), 64'(eMemReq));
      checkOutput("stall_if_arb", 64'(stall_if_arb), 64'(bIfReq && !eIfRvalid));
      checkOutput("stall_mem_arb", 64'(stall_mem_arb), 64'(bDmReq && !eDmRvalid));
      if (eMemReq) begin
         checkOutput("mem_addr", 64'(mem_addr), 64'(mTxnAddr));
         checkOutput("mem_we", 64'(mem_we), 64'(mTxnWe));
         checkOutput("mem_be", 64'(mem_be), 64'(mTxnBe));
         checkOutput("mem_wdata", 64'(mem_wdata), 64'(mTxnWdata));
      end
      lastIfGnt = eIfGnt;
      lastDmGnt = eDmGnt;
      lastAccepted = 1'b0;
      lastMemRvalid = bMemRvalid;
      if (bReset) begin
         resetModel();
      end else begin
         nIf = 1'b0;
         nDm = 1'b0;
         if (mTxnValid && mTxnAccepted) begin
            if (!mTxnOwnerDm && bFlush) mTxnKilled = 1'b1;
            if (bMemRvalid) begin
               if (mTxnOwnerDm) begin
                  nDm = 1'b1;
                  mDmData = bMemRdata;
               end else if (!mTxnKilled) begin
                  nIf = 1'b1;
                  mIfData = bMemRdata;
               end
               mTxnValid = 1'b0;
            end
         end else if (mTxnValid) begin
            if (!mTxnOwnerDm && bFlush) mTxnKilled = 1'b1;
            if (bMemReady) begin
               mTxnAccepted = 1'b1;
               lastAccepted = 1'b1;
            end
         end else if (eIfGnt || eDmGnt) begin
            mTxnValid = 1'b1; mTxnAccepted = 1'b0; mTxnKilled = 1'b0;
            mTxnOwnerDm = eDmGnt;
            mTxnAddr  = eDmGnt ? bDmAddr : bIfAddr;
            mTxnWe    = eDmGnt && bDmWe;
            mTxnBe    = eDmGnt ? bDmBe : '1;
            mTxnWdata = eDmGnt ? bDmWdata : '0;
         end
         if (eIfGnt || !bIfReq) mStarve = 0;
         else if (ifElig && dmElig && eDmGnt && mStarve < STARVE_LIMIT) mStarve++;
         mRespIf = nIf;
         mRespDm = nDm;
      end
   endtask

   // Random requesters (hold until granted) and a memory that answers 1..4
   // cycles after accepting a request.
   task automatic randomInputs();
      if (lastAccepted) begin
         memBusy = 1'b1;
         memDelay = $urandom_range(0, 3);
      end else if (lastMemRvalid) begin
         memBusy = 1'b0;
      end else if (memBusy && memDelay > 0) begin
         memDelay--;
      end
      bReset = 1'b0;
      bMemRvalid = memBusy && memDelay == 0;
      bMemRdata = $urandom;
      bMemReady = ($urandom_range(0, 3) != 0);
      bFlush = ($urandom_range(0, 11) == 0);
      if (lastIfGnt) ifPending = 1'b0;
      if (!ifPending && $urandom_range(0, 2) != 0) begin
         ifPending = 1'b1;
         bIfAddr = $urandom;
      end else if (ifPending && bFlush) begin
         bIfAddr = $urandom;
      end
      bIfReq = ifPending;
      if (lastDmGnt) dmPending = 1'b0;
      if (!dmPending && $urandom_range(0, 3) != 0) begin
         dmPending = 1'b1;
         bDmWe = 1'($urandom_range(0, 1));
         bDmBe = 4'($urandom);
         bDmAddr = $urandom;
         bDmWdata = $urandom;
      end
      bDmReq = dmPending;
   endtask

   initial begin
      logic expectIf;
      resetModel();
      clearInputs();
      bReset = 1'b1;
      lastIfGnt = 1'b0; lastDmGnt = 1'b0; lastAccepted = 1'b0; lastMemRvalid = 1'b0;
      @(posedge clk);
      applyStimulus();
      applyStimulus();
      checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
      checkOutput("rst_if_rvalid", 64'(if_rvalid), 64'd0);
      checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);

      // Single fetch with the fastest memory.
      clearInputs();
      bIfReq = 1'b1; bIfAddr = 32'h100; bMemReady = 1'b1;
      applyStimulus();
      checkOutput("fetch_gnt_c0", 64'(if_gnt), 64'd1);
      bIfReq = 1'b0;
      applyStimulus();
      checkOutput("fetch_mem_req_c1", 64'(mem_req), 64'd1);
      checkOutput("fetch_mem_addr_c1", 64'(mem_addr), 64'h100);
      bMemRvalid = 1'b1; bMemRdata = 32'hDEADBEEF;
      applyStimulus();
      checkOutput("fetch_mem_req_c2", 64'(mem_req), 64'd0);
      bMemRvalid = 1'b0;
      applyStimulus();
      checkOutput("fetch_rvalid_c3", 64'(if_rvalid), 64'd1);
      checkOutput("fetch_rdata_c3", 64'(if_rdata), 64'hDEADBEEF);

      // Contention: the store goes first, the fetch is granted on dm_rvalid.
      clearInputs();
      bMemReady = 1'b1; bIfReq = 1'b1; bIfAddr = 32'h180;
      bDmReq = 1'b1; bDmWe = 1'b1; bDmBe = 4'hF; bDmAddr = 32'h200; bDmWdata = 32'hCAFE0001;
      applyStimulus();
      checkOutput("cont_dm_gnt", 64'(dm_gnt), 64'd1);
      checkOutput("cont_if_nogo", 64'(if_gnt), 64'd0);
      bDmReq = 1'b0;
      applyStimulus();
      checkOutput("cont_mem_we", 64'(mem_we), 64'd1);
      checkOutput("cont_mem_addr", 64'(mem_addr), 64'h200);
      checkOutput("cont_stall_if_c1", 64'(stall_if_arb), 64'd1);
      bMemRvalid = 1'b1;
      applyStimulus();
      checkOutput("cont_stall_if_c2", 64'(stall_if_arb), 64'd1);
      bMemRvalid = 1'b0;
      applyStimulus();
      checkOutput("cont_dm_rvalid", 64'(dm_rvalid), 64'd1);
      checkOutput("cont_if_gnt", 64'(if_gnt), 64'd1);
      checkOutput("cont_stall_if_c3", 64'(stall_if_arb), 64'd1);
      bIfReq = 1'b0;
      applyStimulus();
      bMemRvalid = 1'b1; bMemRdata = 32'h11112222;
      applyStimulus();
      bMemRvalid = 1'b0;
      applyStimulus();
      checkOutput("cont_if_rdata", 64'(if_rdata), 64'h11112222);

      // Backpressure: mem_ready low for five cycles.
      clearInputs();
      bDmReq = 1'b1; bDmAddr = 32'h40; bDmBe = 4'h3;
      applyStimulus();
      checkOutput("bp_dm_gnt", 64'(dm_gnt), 64'd1);
      bDmReq = 1'b0; bIfReq = 1'b1; bIfAddr = 32'h44;
      for (int i = 0; i < 6; i++) begin
         bMemReady = (i == 5);
         applyStimulus();
         checkOutput("bp_mem_req_held", 64'(mem_req), 64'd1);
         checkOutput("bp_mem_addr_held", 64'(mem_addr), 64'h40);
         checkOutput("bp_no_if_gnt", 64'(if_gnt), 64'd0);
      end
      bIfReq = 1'b0; bMemRvalid = 1'b1; bMemRdata = 32'h00005A5A;
      applyStimulus();
      bMemRvalid = 1'b0;
      applyStimulus();
      checkOutput("bp_dm_rvalid", 64'(dm_rvalid), 64'd1);
      checkOutput("bp_dm_rdata", 64'(dm_rdata), 64'h5A5A);

      // Flush while a fetch waits for its response.
      clearInputs();
      bMemReady = 1'b1; bIfReq = 1'b1; bIfAddr = 32'h104;
      applyStimulus();
      bIfReq = 1'b0;
      applyStimulus();
      bFlush = 1'b1;
      applyStimulus();
      bFlush = 1'b0; bMemRvalid = 1'b1; bMemRdata = 32'h0BAD0BAD;
      applyStimulus();
      bMemRvalid = 1'b0; bIfReq = 1'b1; bIfAddr = 32'h300;
      applyStimulus();
      checkOutput("flush_no_rvalid", 64'(if_rvalid), 64'd0);
      checkOutput("flush_rdata_hold", 64'(if_rdata), 64'h11112222);
      checkOutput("flush_new_gnt", 64'(if_gnt), 64'd1);
      bIfReq = 1'b0;
      applyStimulus();
      checkOutput("flush_new_addr", 64'(mem_addr), 64'h300);
      bMemRvalid = 1'b1; bMemRdata = 32'h00000033;
      applyStimulus();
      bMemRvalid = 1'b0;
      applyStimulus();
      checkOutput("flush_new_rvalid", 64'(if_rvalid), 64'd1);

      // Starvation: contested arbitrations with both requests held; a flush in
      // each DM response cycle keeps fetch from winning uncontested.
      clearInputs();
      bMemReady = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bIfReq = 1'b1; bIfAddr = 32'h400; bDmReq = 1'b1; bDmAddr = 32'h600 + 32'(k * 4);
         bFlush = 1'b0;
         applyStimulus();
         expectIf = GUARD_ON && (k == 2);
         checkOutput("starve_if_gnt", 64'(if_gnt), 64'(expectIf));
         checkOutput("starve_dm_gnt", 64'(dm_gnt), 64'(!expectIf));
         applyStimulus();
         bMemRvalid = 1'b1;
         applyStimulus();
         bMemRvalid = 1'b0;
         bFlush = (k < 2);
         if (k == 2) begin
            bIfReq = 1'b0;
            bDmReq = 1'b0;
         end
         applyStimulus();
      end

      // Reset in the middle of WAIT, then a late response.
      clearInputs();
      bMemReady = 1'b1; bIfReq = 1'b1; bIfAddr = 32'h500;
      applyStimulus();
      bIfReq = 1'b0;
      applyStimulus();
      applyStimulus();
      bReset = 1'b1;
      applyStimulus();
      bReset = 1'b0; bMemRvalid = 1'b1; bMemRdata = 32'h77;
      applyStimulus();
      checkOutput("rst2_mem_req", 64'(mem_req), 64'd0);
      checkOutput("rst2_mem_addr", 64'(mem_addr), 64'd0);
      checkOutput("rst2_mem_be", 64'(mem_be), 64'd0);
      checkOutput("rst2_if_rdata", 64'(if_rdata), 64'd0);
      checkOutput("rst2_dm_rdata", 64'(dm_rdata), 64'd0);
      bMemRvalid = 1'b0;
      applyStimulus();
      checkOutput("rst2_late_rvalid", 64'(if_rvalid), 64'd0);

      // Randomized traffic.
      clearInputs();
      ifPending = 1'b0; dmPending = 1'b0; memBusy = 1'b0; memDelay = 0;
      lastAccepted = 1'b0; lastMemRvalid = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         randomInputs();
         applyStimulus();
      end

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
